// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Double-buffered LED matrix scanner. Holds a BPP-bit intensity per pixel in
//   two framebuffer banks. Columns are scanned one-cold and row lines are
//   PWM'd per pixel. A blanking gap at the end of each column stops ghosting.
//   Host logic writes the back bank, then requests a swap. The swap takes
//   effect at the next frame boundary and is a pointer flip, not a copy.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   wr_valid      in   pixel write request
//   wr_ready      out  write accepted when wr_valid & wr_ready at posedge
//   wr_row        in   pixel row
//   wr_col        in   pixel column
//   wr_data       in   pixel intensity
//   swap          in   request a back/front bank swap (pulse or level)
//   bright        in   global brightness ceiling
//   swap_pending  out  swap requested, not yet applied
//   frame_start   out  1-clock pulse on the first clock of column 0
//   rows          out  1 = pixel lit
//   cols          out  one-cold active column; all ones = blank
//
// Build option
//   LEDMX_GAMMA_EN  when defined, intensity goes through a square-law gamma
//                   curve after the brightness clamp.
//                   When undefined, the response is linear.
//
// Phase per column
//   state   | meaning
//   S_DRIVE | tk < P: active column low, rows PWM'd against tk
//   S_BLANK | tk >= P: every column high, every row low

module led_matrix_scan #(
  parameter int NROWS    = 8,
  parameter int NCOLS    = 4,
  parameter int BPP      = 4,
  parameter int PRESCALE = 3,
  parameter int DEADTIME = 2,
  localparam int ROW_W   = (NROWS > 1) ? $clog2(NROWS) : 1,
  localparam int COL_W   = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [BPP-1:0]   wr_data,
  input  logic             swap,
  input  logic [BPP-1:0]   bright,
  output logic             swap_pending,
  output logic             frame_start,
  output logic [NROWS-1:0] rows,
  output logic [NCOLS-1:0] cols
);

  localparam int P     = (1 << BPP) - 1;
  localparam int TKN   = P + DEADTIME;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TK_W  = $clog2(TKN);

  typedef enum logic {S_DRIVE, S_BLANK} phase_t;

  phase_t           state_q, state_n;
  logic [PRE_W-1:0] pre_q, pre_n;
  logic [TK_W-1:0]  tk_q, tk_n;
  logic [COL_W-1:0] col_q, col_n;
  logic             tick, boundary;
  logic             front_q;
  logic             disp_valid;
  logic [NROWS-1:0] rows_n;
  logic [NCOLS-1:0] cols_n;
  logic             wr_fire;

  logic [BPP-1:0] mem [2][NCOLS][NROWS];

  // Clamp to the brightness ceiling, then optionally apply the gamma curve.
  function automatic logic [BPP-1:0] eff(input logic [BPP-1:0] v,
                                         input logic [BPP-1:0] b);
    logic [BPP-1:0] m;
`ifdef LEDMX_GAMMA_EN
    localparam logic [2*BPP:0] ONE_W = 1;
    logic [2*BPP:0] mm;
    logic [2*BPP:0] sq;
`endif
    m = (v < b) ? v : b;
`ifdef LEDMX_GAMMA_EN
    mm  = {{(BPP+1){1'b0}}, m} + ONE_W;
    sq  = mm * mm - ONE_W;
    eff = BPP'(sq >> BPP);
`else
    eff = m;
`endif
  endfunction

  assign wr_ready = ~swap_pending;
  assign wr_fire  = rst_n & wr_valid & ~swap_pending &
                    (32'(wr_row) < NROWS) & (32'(wr_col) < NCOLS);

  always_comb begin
    pre_n    = pre_q;
    tk_n     = tk_q;
    col_n    = col_q;
    tick     = 1'b0;
    boundary = 1'b0;
    rows_n   = '0;
    cols_n   = '1;

    if (pre_q == PRE_W'(PRESCALE - 1)) begin
      pre_n = '0;
      tick  = 1'b1;
    end else begin
      pre_n = pre_q + 1'b1;
    end

    if (tick) begin
      if (tk_q == TK_W'(TKN - 1)) begin
        tk_n = '0;
        if (col_q == COL_W'(NCOLS - 1)) begin
          col_n    = '0;
          boundary = 1'b1;
        end else begin
          col_n = col_q + 1'b1;
        end
      end else begin
        tk_n = tk_q + 1'b1;
      end
    end

    state_n = (tk_n < TK_W'(P)) ? S_DRIVE : S_BLANK;

    // Outputs are computed from this clock's counters and registered, so
    // the pins lag the counters by one clock.
    case (state_q)
      S_DRIVE: begin
        cols_n = ~(NCOLS'(1) << col_q);
        for (int r = 0; r < NROWS; r++) begin
          rows_n[r] = disp_valid &&
                      (TK_W'(eff(mem[front_q][col_q][ROW_W'(r)], bright)) > tk_q);
        end
      end
      default: begin
        rows_n = '0;
        cols_n = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_DRIVE;
      pre_q        <= '0;
      tk_q         <= '0;
      col_q        <= '0;
      front_q      <= 1'b0;
      disp_valid   <= 1'b0;
      swap_pending <= 1'b0;
      frame_start  <= 1'b0;
      rows         <= '0;
      cols         <= '1;
    end else begin
      state_q     <= state_n;
      pre_q       <= pre_n;
      tk_q        <= tk_n;
      col_q       <= col_n;
      frame_start <= boundary;
      rows        <= rows_n;
      cols        <= cols_n;
      // A swap arriving on the boundary clock is not yet pending, so it
      // lands at the following boundary.
      if (boundary && swap_pending) begin
        front_q      <= ~front_q;
        swap_pending <= 1'b0;
        disp_valid   <= 1'b1;
      end else if (swap) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Framebuffer RAM is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[~front_q][wr_col][wr_row] <= wr_data;
    end
  end

endmodule
